// File: rtl/sr14_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sr14_ctrl_pkg
//  Description : Shared constants and state encoding for the 14-bit serial
//                controller and its bit timer.
//  Revision    : 1.0 - initial release
// ============================================================================
package sr14_ctrl_pkg;

    localparam int SR_WIDTH  = 14;
    localparam int BIT_CNT_W = 4;

    // Index of the final bit of a frame, in bit-counter width
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(SR_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : sr14_ctrl_pkg
`default_nettype wire

// File: rtl/sr14_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : sr14_bit_timer
//  Description : Serial-clock divider. Counts 0..2*CLK_DIV-1 while a frame is
//                shifting, drives sclk and the sample/shift strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module sr14_bit_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic run,
    output logic sclk,
    output logic sample_stb,
    output logic shift_stb
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] C_HALF = DIV_W'(CLK_DIV);
    localparam logic [DIV_W-1:0] C_LAST = DIV_W'(2 * CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;

    // Divider advances only while running and wraps each bit period
    always_comb begin
        div_cnt_d = '0;
        if (run) begin
            div_cnt_d = (div_cnt_q == C_LAST) ? '0 : div_cnt_q + 1'b1;
        end
    end

    // Divider register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    // First half of each bit period is sclk low, second half high
    assign sclk       = run && (div_cnt_q >= C_HALF);
    assign sample_stb = run && (div_cnt_q == C_HALF);
    assign shift_stb  = run && (div_cnt_q == C_LAST);

endmodule : sr14_bit_timer
`default_nettype wire

// File: rtl/sr14_serial_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sr14_serial_ctrl
//  Description : Full-duplex 14-bit serial controller driving an external
//                muxed shift register. MSB out first; received bits enter at
//                bit 0 so the first received bit ends up in bit 13.
//  Revision    : 1.0 - initial release
// ============================================================================
module sr14_serial_ctrl
    import sr14_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [SR_WIDTH-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic [SR_WIDTH-1:0] rx_data,
    output logic                rx_valid,
    output logic                sr_enable,
    output logic                sr_select,
    output logic [SR_WIDTH-1:0] sr_d,
    input  logic [SR_WIDTH-1:0] sr_q,
    output logic                sclk,
    output logic                cs_n,
    output logic                sdo,
    input  logic                sdi
);

    state_t                 state_q, state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                   sdi_q, sdi_d;
    logic [SR_WIDTH-1:0]    rx_data_q, rx_data_d;

    logic                   run;
    logic                   sample_stb;
    logic                   shift_stb;
    logic                   shift_bit;

    assign run = (state_q == ST_SHIFT);

    sr14_bit_timer #(
        .CLK_DIV    (CLK_DIV)
    ) u_bit_timer (
        .clk        (clk),
        .resetn     (resetn),
        .run        (run),
        .sclk       (sclk),
        .sample_stb (sample_stb),
        .shift_stb  (shift_stb)
    );

    // With CLK_DIV=1 the sample and shift cycles coincide, so the live sdi
    // value must bypass sdi_q or the shift would use the previous bit.
    assign shift_bit = sample_stb ? sdi : sdi_q;

    // Next-state and output decode for the IDLE/SHIFT/DONE controller
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sdi_d     = sdi_q;
        rx_data_d = rx_data_q;
        tx_ready  = 1'b0;
        cs_n      = 1'b1;
        rx_valid  = 1'b0;
        sr_enable = 1'b0;
        sr_select = 1'b0;
        sr_d      = '0;
        case (state_q)
            ST_IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    sr_enable = 1'b1;
                    sr_select = 1'b1;
                    sr_d      = tx_data;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                cs_n = 1'b0;
                if (sample_stb) begin
                    sdi_d = sdi;
                end
                if (shift_stb) begin
                    sr_enable = 1'b1;
                    sr_d      = {{(SR_WIDTH-1){1'b0}}, shift_bit};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = ST_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                rx_valid  = 1'b1;
                rx_data_d = sr_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Never touch the external register or flag data while held in reset
        if (!resetn) begin
            sr_enable = 1'b0;
            sr_select = 1'b0;
            sr_d      = '0;
            rx_valid  = 1'b0;
        end
    end

    // Controller state and datapath registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            sdi_q     <= 1'b0;
            rx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sdi_q     <= sdi_d;
            rx_data_q <= rx_data_d;
        end
    end

    assign rx_data = rx_data_q;
    assign sdo     = ~cs_n & sr_q[SR_WIDTH-1];

endmodule : sr14_serial_ctrl
`default_nettype wire

// File: tb/tb_sr14_serial_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sr14_serial_ctrl
//  Description : Directed bench for sr14_serial_ctrl. Instance A uses
//                CLK_DIV=4, instance B uses CLK_DIV=1 for back-to-back frames.
//                Each instance drives a behavioural 14-bit muxed shift reg.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sr14_serial_ctrl;

    logic clk;
    int   n_cmp = 0;
    int   n_err = 0;

    // ---------------- instance A (CLK_DIV = 4) ----------------
    logic        a_resetn, a_tx_valid, a_tx_ready, a_rx_valid;
    logic        a_sr_enable, a_sr_select, a_sclk, a_cs_n, a_sdo, a_sdi;
    logic [13:0] a_tx_data, a_rx_data, a_sr_d;
    logic [13:0] a_sr_q = '0;
    int          a_mode = 0;        // 0 loopback, 1 sdi tied 1, 2 sdi tied 0

    int          a_rx_cyc, a_shifts, a_extra_loads, a_sclk_hi, a_csn_lo;
    logic [13:0] a_sdo_word;

    // ---------------- instance B (CLK_DIV = 1) ----------------
    logic        b_resetn, b_tx_valid, b_tx_ready, b_rx_valid;
    logic        b_sr_enable, b_sr_select, b_sclk, b_cs_n, b_sdo, b_sdi;
    logic [13:0] b_tx_data, b_rx_data, b_sr_d;
    logic [13:0] b_sr_q = '0;

    int          b_rx1, b_rx2, b_loads, b_gap;
    logic [13:0] b_rxd1, b_rxd2;
    int          a_rxv_cnt, a_csn_cnt;

    assign a_sdi = (a_mode == 0) ? a_sdo : (a_mode == 1);
    assign b_sdi = b_sdo;

    sr14_serial_ctrl #(.CLK_DIV(4)) u_dut_a (
        .clk(clk), .resetn(a_resetn), .tx_data(a_tx_data), .tx_valid(a_tx_valid),
        .tx_ready(a_tx_ready), .rx_data(a_rx_data), .rx_valid(a_rx_valid),
        .sr_enable(a_sr_enable), .sr_select(a_sr_select), .sr_d(a_sr_d),
        .sr_q(a_sr_q), .sclk(a_sclk), .cs_n(a_cs_n), .sdo(a_sdo), .sdi(a_sdi)
    );

    sr14_serial_ctrl #(.CLK_DIV(1)) u_dut_b (
        .clk(clk), .resetn(b_resetn), .tx_data(b_tx_data), .tx_valid(b_tx_valid),
        .tx_ready(b_tx_ready), .rx_data(b_rx_data), .rx_valid(b_rx_valid),
        .sr_enable(b_sr_enable), .sr_select(b_sr_select), .sr_d(b_sr_d),
        .sr_q(b_sr_q), .sclk(b_sclk), .cs_n(b_cs_n), .sdo(b_sdo), .sdi(b_sdi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External muxed shift registers: load when select=1, else shift up
    always @(posedge clk) begin
        if (a_sr_enable) a_sr_q <= a_sr_select ? a_sr_d : {a_sr_q[12:0], a_sr_d[0]};
        if (b_sr_enable) b_sr_q <= b_sr_select ? b_sr_d : {b_sr_q[12:0], b_sr_d[0]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame on instance A: handshake, then observe until rx_valid
    // (bounded); returns one cycle after the rx_valid cycle.
    task automatic a_frame(input logic [13:0] w, input int pulse_cyc);
        a_rx_cyc = 0; a_shifts = 0; a_extra_loads = 0;
        a_sclk_hi = 0; a_csn_lo = 0; a_sdo_word = '0;
        @(negedge clk);
        check("a_ready_before_frame", 32'(a_tx_ready), 32'd1);
        a_tx_data  = w;
        a_tx_valid = 1'b1;
        @(posedge clk);
        #1;
        a_tx_valid = 1'b0;
        a_tx_data  = 14'($urandom);
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (a_sr_enable && !a_sr_select) begin
                a_shifts++;
                a_sdo_word = {a_sdo_word[12:0], a_sdo};
            end
            if (a_sr_enable && a_sr_select) a_extra_loads++;
            if (a_sclk) a_sclk_hi++;
            if (!a_cs_n) a_csn_lo++;
            if (cyc == pulse_cyc) begin
                a_tx_data  = 14'h1111;
                a_tx_valid = 1'b1;
            end else if (cyc == pulse_cyc + 1) begin
                a_tx_valid = 1'b0;
                a_tx_data  = '0;
            end
            if (a_rx_valid) begin
                a_rx_cyc = cyc;
                break;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        a_resetn = 1'b0; a_tx_valid = 1'b0; a_tx_data = '0;
        b_resetn = 1'b0; b_tx_valid = 1'b0; b_tx_data = '0;
        repeat (3) @(negedge clk);

        // ---- reset state ----
        check("rst_tx_ready", 32'(a_tx_ready), 32'd1);
        check("rst_cs_n",     32'(a_cs_n),     32'd1);
        check("rst_sclk",     32'(a_sclk),     32'd0);
        check("rst_rx_valid", 32'(a_rx_valid), 32'd0);
        check("rst_rx_data",  32'(a_rx_data),  32'h0);
        check("rst_sdo",      32'(a_sdo),      32'd0);
        check("b_rst_tx_ready", 32'(b_tx_ready), 32'd1);
        // tx_valid while held in reset must not enable the shift register
        a_tx_valid = 1'b1; a_tx_data = 14'h2222;
        #1;
        check("rst_sr_enable_gated", 32'(a_sr_enable), 32'd0);
        check("rst_sr_d_zero",       32'(a_sr_d),      32'h0);
        @(negedge clk);
        a_tx_valid = 1'b0;
        a_resetn = 1'b1; b_resetn = 1'b1;
        @(negedge clk);
        check("post_rst_cs_n",   32'(a_cs_n),   32'd1);
        check("post_rst_sr_q",   32'(a_sr_q),   32'h0);

        // ---- loopback 2A5C ----
        a_mode = 0;
        a_frame(14'h2A5C, -10);
        check("lb_rx_cycle",    32'(a_rx_cyc),      32'd113);
        check("lb_shifts",      32'(a_shifts),      32'd14);
        check("lb_extra_loads", 32'(a_extra_loads), 32'd0);
        check("lb_sdo_word",    32'(a_sdo_word),    32'h2A5C);
        check("lb_sclk_hi",     32'(a_sclk_hi),     32'd56);
        check("lb_csn_lo",      32'(a_csn_lo),      32'd112);
        check("lb_rx_data",     32'(a_rx_data),     32'h2A5C);
        check("lb_rx_valid_1c", 32'(a_rx_valid),    32'd0);
        check("lb_tx_ready",    32'(a_tx_ready),    32'd1);
        repeat (3) @(negedge clk);
        check("lb_rx_hold",     32'(a_rx_data),     32'h2A5C);

        // ---- sdi tied 1, send zeros ----
        a_mode = 1;
        a_frame(14'h0000, -10);
        check("one_sdo_word", 32'(a_sdo_word), 32'h0000);
        check("one_rx_data",  32'(a_rx_data),  32'h3FFF);
        check("one_shifts",   32'(a_shifts),   32'd14);

        // ---- sdi tied 0, send ones ----
        a_mode = 2;
        a_frame(14'h3FFF, -10);
        check("zero_sdo_word", 32'(a_sdo_word), 32'h3FFF);
        check("zero_rx_data",  32'(a_rx_data),  32'h0000);

        // ---- tx_valid pulse during SHIFT is ignored ----
        a_mode = 0;
        a_frame(14'h0F0F, 20);
        check("ign_extra_loads", 32'(a_extra_loads), 32'd0);
        check("ign_rx_cycle",    32'(a_rx_cyc),      32'd113);
        check("ign_rx_data",     32'(a_rx_data),     32'h0F0F);

        // ---- reset during bit 7 (cycles 57..64) ----
        @(negedge clk);
        a_tx_data = 14'h1C3A; a_tx_valid = 1'b1;
        @(posedge clk);
        #1;
        a_tx_valid = 1'b0;
        for (int cyc = 1; cyc < 60; cyc++) @(negedge clk);
        @(negedge clk);
        check("abort_mid_frame_cs_n", 32'(a_cs_n), 32'd0);
        a_resetn = 1'b0; a_tx_valid = 1'b1; a_tx_data = 14'h1555;
        #1;
        check("abort_sr_enable_low", 32'(a_sr_enable), 32'd0);
        @(negedge clk);
        check("abort_cs_n",      32'(a_cs_n),      32'd1);
        check("abort_sclk",      32'(a_sclk),      32'd0);
        check("abort_tx_ready",  32'(a_tx_ready),  32'd1);
        check("abort_sr_enable", 32'(a_sr_enable), 32'd0);
        a_resetn = 1'b1; a_tx_valid = 1'b0;
        a_rxv_cnt = 0; a_csn_cnt = 0;
        for (int cyc = 0; cyc < 150; cyc++) begin
            @(negedge clk);
            if (a_rx_valid) a_rxv_cnt++;
            if (!a_cs_n) a_csn_cnt++;
        end
        check("abort_no_rx_valid", 32'(a_rxv_cnt), 32'd0);
        check("abort_stays_idle",  32'(a_csn_cnt), 32'd0);
        a_frame(14'h15A3, -10);
        check("after_abort_rx_cycle", 32'(a_rx_cyc), 32'd113);
        check("after_abort_rx_data",  32'(a_rx_data), 32'h15A3);
        check("after_abort_shifts",   32'(a_shifts), 32'd14);

        // ---- instance B: CLK_DIV=1 back-to-back frames ----
        b_rx1 = 0; b_rx2 = 0; b_loads = 0; b_gap = 0; b_rxd1 = '0; b_rxd2 = '0;
        @(negedge clk);
        b_tx_data = 14'h3FFF; b_tx_valid = 1'b1;
        @(posedge clk);
        #1;
        b_tx_data = 14'h0001;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (b_rx1 != 0 && cyc == b_rx1 + 1) b_rxd1 = b_rx_data;
            if (b_sr_enable && b_sr_select) b_loads++;
            if (b_rx_valid) begin
                if (b_rx1 == 0) b_rx1 = cyc;
                else            b_rx2 = cyc;
            end
            if (b_cs_n && b_rx2 == 0) b_gap++;
            if (b_loads >= 1 && !b_cs_n) b_tx_valid = 1'b0;
            if (b_rx2 != 0 && cyc == b_rx2 + 1) begin
                b_rxd2 = b_rx_data;
                break;
            end
        end
        check("b2b_rx1_cycle", 32'(b_rx1),      32'd29);
        check("b2b_rx2_cycle", 32'(b_rx2),      32'd59);
        check("b2b_reloads",   32'(b_loads),    32'd1);
        check("b2b_csn_gap",   32'(b_gap),      32'd2);
        check("b2b_rx_data1",  32'(b_rxd1),     32'h3FFF);
        check("b2b_rx_data2",  32'(b_rxd2),     32'h0001);
        check("b2b_tx_ready",  32'(b_tx_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_sr14_serial_ctrl
`default_nettype wire
